// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES data-link SPI responder and its master.
package aes_spi_pkg;

  localparam int DATASIZE = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_slv_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Per-pin level/edge extractor: optional 2-flop synchronizer (SPI_SLAVE_SYNC_EN)
// followed by a delay flop producing rise/fall pulses in the clk domain.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] sync;

  // Two-stage synchronizer for a pin asynchronous to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], din};
    end
  end

  assign level = sync[1];
`else
  assign level = din;
`endif

  // Previous level; resetting low means a pin held low out of reset never
  // produces a falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder (mode 0, MSB first) for the AES data link; one shared shift
// register receives on mosi and returns on miso. Optional SPI_SLAVE_SYNC_EN.
module spi_slave
  import aes_spi_pkg::*;
#(
  parameter int datasize = DATASIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                scs,
  input  logic                mosi,
  output logic                miso,
  input  logic [datasize-1:0] tx_data,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic [datasize-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_err
);

  localparam int CW = $clog2(datasize) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(datasize);

  spi_slv_state_t      state, state_n;
  logic [datasize-1:0] sr, sr_n, rx_data_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                miso_n, rx_valid_n, frame_err_n;
  logic                sclk_s, rise, fall;
  logic                scs_s, cs_rise, cs_fall;
  logic                mosi_s, mosi_rise, mosi_fall;
  logic                unused_edges;

  spi_edge_sync u_sclk (.clk(clk), .rst(rst), .din(sclk), .level(sclk_s), .rise(rise),      .fall(fall));
  spi_edge_sync u_scs  (.clk(clk), .rst(rst), .din(scs),  .level(scs_s),  .rise(cs_rise),   .fall(cs_fall));
  spi_edge_sync u_mosi (.clk(clk), .rst(rst), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_edges = ^{sclk_s, scs_s, mosi_rise, mosi_fall};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      miso      <= miso_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state and datapath; a shift is applied before cs_rise is judged
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    miso_n      = miso;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (tx_load) begin
          sr_n = tx_data;
        end else begin
          sr_n = sr;
        end
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          miso_n  = sr_n[datasize-1];
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (rise && (cnt < CNT_FULL)) begin
          sr_n  = {sr[datasize-2:0], mosi_s};
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = cnt;
        end
        if (fall) begin
          miso_n = sr[datasize-1];
        end else begin
          miso_n = miso;
        end
        if (cnt_n == CNT_FULL) begin
          rx_data_n  = sr_n;
          rx_valid_n = 1'b1;
          state_n    = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          frame_err_n = 1'b1;
          state_n     = IDLE;
        end else begin
          state_n = SHIFT;
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign tx_ready = (state == IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave acting as a mode-0 SPI master.
module tb_spi_slave;

  localparam int HALF = 6;

  logic         clk;
  logic         rst;
  logic         sclk;
  logic         scs;
  logic         mosi;
  logic         miso;
  logic [127:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic         frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cycles = 0;
  int ferr_cycles = 0;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .scs(scs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle a pulse output is high, so a stretched pulse shows up
  always @(posedge clk) begin
    if (rx_valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [127:0] mo, input int nbits, input logic load_at_cs,
                           input logic [127:0] load_val, output logic [127:0] mi);
    logic [127:0] sh;
    sh = mo;
    mi = '0;
    @(negedge clk);
    scs  = 1'b0;
    mosi = sh[127];
    if (load_at_cs) begin
      tx_data = load_val;
      tx_load = 1'b1;
    end
    @(negedge clk);
    tx_load = 1'b0;
    repeat (HALF) @(negedge clk);
    check_eq("tx_ready_busy", 128'(tx_ready), 128'd0);
    for (int i = 0; i < nbits; i++) begin
      mi   = {mi[126:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      sh   = {sh[126:0], 1'b0};
      mosi = sh[127];
      repeat (HALF) @(negedge clk);
    end
    scs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] mi;
    logic [127:0] a_tx, a_rx, b_rx, c_rx, ov_rx, ld_tx;
    int v0, f0;
    a_tx  = 128'h00112233445566778899AABBCCDDEEFF;
    a_rx  = 128'h0123456789ABCDEFFEDCBA9876543210;
    b_rx  = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_8765;
    c_rx  = 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF;
    ov_rx = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    ld_tx = 128'hF00DCAFE_00000000_FFFFFFFF_80000001;

    rst = 1'b0; sclk = 1'b0; scs = 1'b1; mosi = 1'b0; tx_data = '0; tx_load = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", 128'(miso), 128'd0);
    check_eq("rst_rx_valid", 128'(rx_valid), 128'd0);
    check_eq("rst_frame_err", 128'(frame_err), 128'd0);
    check_eq("rst_rx_data", rx_data, 128'd0);
    check_eq("rst_tx_ready", 128'(tx_ready), 128'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame with preloaded reply
    tx_data = a_tx; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    v0 = valid_cycles; f0 = ferr_cycles;
    spi_frame(a_rx, 128, 1'b0, '0, mi);
    check_eq("full_miso", mi, a_tx);
    check_eq("full_rx_data", rx_data, a_rx);
    check_eq("full_rx_valid_cycles", 128'(valid_cycles - v0), 128'd1);
    check_eq("full_no_ferr", 128'(ferr_cycles - f0), 128'd0);
    check_eq("full_tx_ready", 128'(tx_ready), 128'd1);

    // Echo of the received block
    v0 = valid_cycles;
    spi_frame(b_rx, 128, 1'b0, '0, mi);
    check_eq("echo_miso", mi, a_rx);
    check_eq("echo_rx_data", rx_data, b_rx);
    check_eq("echo_rx_valid_cycles", 128'(valid_cycles - v0), 128'd1);

    // Short frame of 64 bits
    v0 = valid_cycles; f0 = ferr_cycles;
    spi_frame(c_rx, 64, 1'b0, '0, mi);
    check_eq("short_ferr_cycles", 128'(ferr_cycles - f0), 128'd1);
    check_eq("short_no_valid", 128'(valid_cycles - v0), 128'd0);
    check_eq("short_rx_data", rx_data, b_rx);
    check_eq("short_tx_ready", 128'(tx_ready), 128'd1);

    // Reset mid-frame at bit 40, then extra clocking with scs still low
    v0 = valid_cycles; f0 = ferr_cycles;
    @(negedge clk);
    scs = 1'b0; mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; mosi = ~mosi; repeat (HALF) @(negedge clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_miso", 128'(miso), 128'd0);
    check_eq("midrst_rx_data", rx_data, 128'd0);
    check_eq("midrst_tx_ready", 128'(tx_ready), 128'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; mosi = ~mosi; repeat (HALF) @(negedge clk);
    end
    check_eq("midrst_tx_ready_ignored", 128'(tx_ready), 128'd1);
    scs = 1'b1;
    repeat (HALF) @(negedge clk);
    check_eq("midrst_no_valid", 128'(valid_cycles - v0), 128'd0);
    check_eq("midrst_no_ferr", 128'(ferr_cycles - f0), 128'd0);
    check_eq("midrst_rx_data_after", rx_data, 128'd0);

    // Next proper frame after reset: reply is the cleared register
    v0 = valid_cycles;
    spi_frame(c_rx, 128, 1'b0, '0, mi);
    check_eq("post_rst_miso", mi, 128'd0);
    check_eq("post_rst_rx_data", rx_data, c_rx);
    check_eq("post_rst_valid_cycles", 128'(valid_cycles - v0), 128'd1);

    // Overlong clocking: 140 sclk cycles, only the first 128 bits count
    v0 = valid_cycles; f0 = ferr_cycles;
    spi_frame(ov_rx, 140, 1'b0, '0, mi);
    check_eq("long_rx_data", rx_data, ov_rx);
    check_eq("long_valid_cycles", 128'(valid_cycles - v0), 128'd1);
    check_eq("long_no_ferr", 128'(ferr_cycles - f0), 128'd0);

    // tx_load coincident with cs_fall supplies the first miso bit
    spi_frame(b_rx, 128, 1'b1, ld_tx, mi);
    check_eq("ldcs_first_bit", 128'(mi[127]), 128'd1);
    check_eq("ldcs_miso", mi, ld_tx);
    check_eq("ldcs_rx_data", rx_data, b_rx);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder that pairs with the team's SPI master on the AES data link. It receives one `datasize`-bit block MSB-first on `mosi` while returning a preloaded block MSB-first on `miso` in the same frame. A received block is handed to the AES core with a one-cycle valid pulse. `sclk`, `scs` and `mosi` are oversampled in the local `clk` domain, so `clk` must run at least 4x the `sclk` rate.

## Interface
- `datasize`, 128: frame length in bits; also the width of the block registers.
- `clk`  in  1  local system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  serial clock from the master.
- `scs`  in  1  chip select from the master, active-low.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master, registered.
- `tx_data`  in  datasize  block to return in the next frame.
- `tx_load`  in  1  load strobe for `tx_data`; accepted only while `tx_ready`=1.
- `tx_ready`  out  1  high in IDLE only.
- `rx_data`  out  datasize  last complete received block; held until the next complete frame.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse on a short frame.

## Operation
- A single shift register `sr[datasize-1:0]` serves both directions.
  - It shifts left with `mosi` entering at the LSB.
  - `miso` is taken from `sr[MSB]`.
  - After a full frame, `sr` holds the received block. If nothing is reloaded, the next frame echoes that block.
- Edge detect works on the internal (optionally synchronized) copies `sclk_s` and `scs_s`:
  - `rise = sclk_s & ~sclk_q`, and `fall` likewise.
  - `cs_fall` and `cs_rise` are derived from `scs_s` in the same way.
- **IDLE**: `tx_ready`=1.
  - `tx_load` sets `sr <= tx_data`.
  - On `cs_fall`: go to SHIFT, clear the bit counter `cnt`, and set `miso <= sr[MSB]`. If `tx_load` is high in that same cycle, `tx_data[MSB]` is used.
  - IDLE is entered only after `scs_s` has been seen high. A low `scs` coming out of reset does not start a frame.
- **SHIFT**:
  - On `rise`: `sr <= {sr[datasize-2:0], mosi_s}` and `cnt <= cnt+1`.
  - On `fall`: `miso <= sr[MSB]`.
  - When `cnt` reaches `datasize`: `rx_data <= sr` and pulse `rx_valid`, then go to DONE.
  - On `cs_rise` with `cnt < datasize`: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE. `sr` keeps the partially shifted contents.
- **DONE**: all `sclk` edges are ignored and `miso` holds its last value. On `cs_rise`, go to IDLE.
- `cnt` is `$clog2(datasize)+1` bits wide and saturates at `datasize`. It never wraps.
- `rise` and `cs_rise` in the same cycle: the bit is shifted first, then `cs_rise` is evaluated against the updated `cnt`.

## Timing
- Reset values:
  - `miso`=0, `rx_valid`=0, `frame_err`=0, `rx_data`=0, `sr`=0.
  - State = IDLE; `tx_ready`=1 (combinational from state).
- Reset asserted mid-frame aborts immediately. No `rx_valid` or `frame_err` pulse is generated.
- Input latency, pin change to edge detect:
  - 1 `clk` without the sync feature.
  - 3 `clk` with the sync feature.
- `miso` updates 1 `clk` after `fall` (or after `cs_fall`) is detected. It must be stable before the master's next `sclk` rise.
- `rx_valid` goes high the cycle after the `rise` detect that completes the frame, for exactly 1 cycle.
- `frame_err` goes high the cycle after `cs_rise` is detected, for exactly 1 cycle.
- `tx_ready` drops the cycle after `cs_fall` is detected. It rises the cycle after `cs_rise` is detected in DONE, or on abort.

## Configuration
- `SPI_SLAVE_SYNC_EN`:
  - Defined: `sclk`, `scs` and `mosi` each pass through a 2-flop synchronizer before edge detect. Use this when the master is asynchronous to `clk`.
  - Undefined: the pins feed edge detect directly, which requires `sclk` to be derived synchronously from `clk`. All other behaviour is identical, apart from the 2-cycle latency difference stated in Timing.

## Structure
- Package `aes_spi_pkg` holds:
  - the state enum `spi_slv_state_t` {IDLE, SHIFT, DONE};
  - the default `DATASIZE` = 128, shared with the master.
- One sub-module, `spi_edge_sync`:
  - per-signal optional synchronizer plus the delay flop;
  - outputs the synchronized level and the rise and fall pulses;
  - instantiated for `sclk` and `scs`; `mosi` uses only its level output.

## Test plan
- Full frame: load `tx_data`=128'h0011...EEFF, master sends 128'h0123456789ABCDEF_FEDCBA9876543210 → master receives 0011...EEFF, `rx_data` = 0123...3210, exactly one `rx_valid` pulse.
- Echo: second frame with no `tx_load` → `miso` returns 0123...3210.
- Short frame: `scs` rises after 64 bits → one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, `tx_ready`=1.
- Reset mid-frame at bit 40 with `scs` still low → all outputs at reset values, extra `sclk` edges ignored, the next proper frame is received correctly.
- Overlong clocking: 140 `sclk` cycles with `scs` low → `rx_valid` after bit 128 only, `rx_data` = the first 128 bits.
- `tx_load` in the same cycle as `cs_fall` → the first `miso` bit is the new `tx_data[127]`.
